// File: rtl/cb_dct_pkg.sv
// Shared definitions for the Cb-plane 8x8 forward DCT.
//   - datapath widths for each stage of the separable transform
//   - coefficient ROM C[u][x] = round(2^12 * a(u) * cos((2x+1)u*pi/16))
//   - controller state encoding
//   - round-half-up / saturate helper for the final coefficient
package cb_dct_pkg;

    localparam int COEF_FRAC = 12;
    localparam int PIX_W     = 8;
    localparam int SHIFT_W   = 9;
    localparam int COEF_W    = 14;
    localparam int ROW_W     = 26;
    localparam int ACC_W     = 43;
    localparam int OUT_W     = 11;

    typedef enum logic [1:0] {
        LOAD    = 2'd0,
        COMPUTE = 2'd1,
        DONE    = 2'd2
    } state_t;

    // Distinct magnitudes: DC scale and 2048*cos(k*pi/16) for k = 1..7.
    localparam logic signed [COEF_W-1:0] C0 = 14'sd1448;
    localparam logic signed [COEF_W-1:0] C1 = 14'sd2009;
    localparam logic signed [COEF_W-1:0] C2 = 14'sd1892;
    localparam logic signed [COEF_W-1:0] C3 = 14'sd1703;
    localparam logic signed [COEF_W-1:0] C4 = 14'sd1448;
    localparam logic signed [COEF_W-1:0] C5 = 14'sd1138;
    localparam logic signed [COEF_W-1:0] C6 = 14'sd784;
    localparam logic signed [COEF_W-1:0] C7 = 14'sd400;

    localparam logic signed [COEF_W-1:0] COEF [8][8] = '{
        '{ C0,  C0,  C0,  C0,  C0,  C0,  C0,  C0},
        '{ C1,  C3,  C5,  C7, -C7, -C5, -C3, -C1},
        '{ C2,  C6, -C6, -C2, -C2, -C6,  C6,  C2},
        '{ C3, -C7, -C1, -C5,  C5,  C1,  C7, -C3},
        '{ C4, -C4, -C4,  C4,  C4, -C4, -C4,  C4},
        '{ C5, -C1,  C7,  C3, -C3, -C7,  C1, -C5},
        '{ C6, -C2,  C2, -C6, -C6,  C2, -C2,  C6},
        '{ C7, -C5,  C3, -C1,  C1, -C3,  C5, -C7}
    };

    // Two coefficient passes leave 2*COEF_FRAC fractional bits.
    localparam logic signed [ACC_W-1:0] RND   = ACC_W'(1 << (2*COEF_FRAC - 1));
    localparam logic signed [ACC_W-1:0] Z_MAX = ACC_W'(1023);
    localparam logic signed [ACC_W-1:0] Z_MIN = ACC_W'(-1024);

    function automatic logic signed [OUT_W-1:0] round_sat(input logic signed [ACC_W-1:0] w);
        logic signed [ACC_W-1:0] t;
        t = (w + RND) >>> (2*COEF_FRAC);
        if (t > Z_MAX)
            return Z_MAX[OUT_W-1:0];
        else if (t < Z_MIN)
            return Z_MIN[OUT_W-1:0];
        else
            return t[OUT_W-1:0];
    endfunction

endpackage

// File: rtl/cb_dct_dot8.sv
// Combinational 8-term signed dot product against one row of the DCT
// coefficient ROM.
//   x   : eight signed DATA_W operands, element i at bits [i*DATA_W +: DATA_W]
//   sel : coefficient row (frequency index) to multiply against
//   dot : signed SUM_W result, sum_i x[i] * COEF[sel][i]
module dct_dot8
    import cb_dct_pkg::*;
#(
    parameter int DATA_W = 9,
    parameter int SUM_W  = 26
) (
    input  logic [8*DATA_W-1:0]     x,
    input  logic [2:0]              sel,
    output logic signed [SUM_W-1:0] dot
);

    logic signed [SUM_W-1:0] xe;
    logic signed [SUM_W-1:0] ce;
    logic signed [SUM_W-1:0] acc;

    // SUM_W is sized so the full-precision sum never overflows; products are
    // formed at SUM_W directly so no intermediate truncation can occur.
    always_comb begin
        xe  = '0;
        ce  = '0;
        acc = '0;
        for (int i = 0; i < 8; i++) begin
            xe  = {{(SUM_W-DATA_W){x[i*DATA_W + DATA_W - 1]}}, x[i*DATA_W +: DATA_W]};
            ce  = {{(SUM_W-COEF_W){COEF[sel][i][COEF_W-1]}}, COEF[sel][i]};
            acc = acc + xe * ce;
        end
        dot = acc;
    end

endmodule

// File: rtl/cb_dct.sv
// Forward 8x8 2-D DCT for the Cb plane.
//   clk, rst          : clock, asynchronous active-high reset
//   enable, data_in   : one unsigned pixel per enabled cycle, row-major
//   output_enable     : high while Z*_final hold a completed block
//   Zrc_final         : signed coefficient, r = vertical freq + 1, c = horizontal freq + 1
//
//   state   | meaning
//   LOAD    | accepting pixels; each full row is transformed on the next edge
//   COMPUTE | last row pass, then one column per edge; input ignored
//   DONE    | results held; first enabled pixel starts a new block
module cb_dct
    import cb_dct_pkg::*;
(
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    enable,
    input  logic [PIX_W-1:0]        data_in,
    output logic                    output_enable,
    output logic signed [OUT_W-1:0] Z11_final, Z12_final, Z13_final, Z14_final,
                                    Z15_final, Z16_final, Z17_final, Z18_final,
    output logic signed [OUT_W-1:0] Z21_final, Z22_final, Z23_final, Z24_final,
                                    Z25_final, Z26_final, Z27_final, Z28_final,
    output logic signed [OUT_W-1:0] Z31_final, Z32_final, Z33_final, Z34_final,
                                    Z35_final, Z36_final, Z37_final, Z38_final,
    output logic signed [OUT_W-1:0] Z41_final, Z42_final, Z43_final, Z44_final,
                                    Z45_final, Z46_final, Z47_final, Z48_final,
    output logic signed [OUT_W-1:0] Z51_final, Z52_final, Z53_final, Z54_final,
                                    Z55_final, Z56_final, Z57_final, Z58_final,
    output logic signed [OUT_W-1:0] Z61_final, Z62_final, Z63_final, Z64_final,
                                    Z65_final, Z66_final, Z67_final, Z68_final,
    output logic signed [OUT_W-1:0] Z71_final, Z72_final, Z73_final, Z74_final,
                                    Z75_final, Z76_final, Z77_final, Z78_final,
    output logic signed [OUT_W-1:0] Z81_final, Z82_final, Z83_final, Z84_final,
                                    Z85_final, Z86_final, Z87_final, Z88_final
);

    state_t state, state_nxt;

    logic [5:0] count;
    logic [3:0] tmr;
    logic       row_ready;
    logic [2:0] row_idx;
    logic       accept;
    logic       col_active;
    logic [2:0] col_sel;

    logic signed [SHIFT_W-1:0] row_buf [8];
    logic signed [ROW_W-1:0]   y_buf   [8][8];
    logic signed [OUT_W-1:0]   z_reg   [8][8];

    logic [8*SHIFT_W-1:0]      row_flat;
    logic [8*ROW_W-1:0]        col_flat;
    logic signed [ROW_W-1:0]   row_dot [8];
    logic signed [ACC_W-1:0]   col_dot [8];

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            state <= LOAD;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt  = state;
        accept     = 1'b0;
        col_active = 1'b0;
        case (state)
            LOAD: begin
                accept = enable;
                if (enable && count == 6'd63)
                    state_nxt = COMPUTE;
            end
            COMPUTE: begin
                // tmr = 9 is the slot where the final row pass lands.
                col_active = (tmr <= 4'd8);
                if (tmr == 4'd1)
                    state_nxt = DONE;
            end
            DONE: begin
                accept = enable;
                if (enable)
                    state_nxt = LOAD;
            end
            default: state_nxt = LOAD;
        endcase
    end

    // Down-counter 8..1 walks columns 0..7.
    assign col_sel = 3'(4'd8 - tmr);

    always_comb begin
        row_flat = '0;
        col_flat = '0;
        for (int i = 0; i < 8; i++) begin
            row_flat[i*SHIFT_W +: SHIFT_W] = row_buf[i];
            col_flat[i*ROW_W +: ROW_W]     = y_buf[i][col_sel];
        end
    end

    // Row pass: one dot product per horizontal frequency u.
    // Column pass: one dot product per vertical frequency v, on column col_sel.
    for (genvar g = 0; g < 8; g++) begin : g_dot
        dct_dot8 #(.DATA_W(SHIFT_W), .SUM_W(ROW_W)) u_row (
            .x   (row_flat),
            .sel (3'(g)),
            .dot (row_dot[g])
        );
        dct_dot8 #(.DATA_W(ROW_W), .SUM_W(ACC_W)) u_col (
            .x   (col_flat),
            .sel (3'(g)),
            .dot (col_dot[g])
        );
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count         <= '0;
            tmr           <= '0;
            row_ready     <= 1'b0;
            row_idx       <= '0;
            output_enable <= 1'b0;
            for (int i = 0; i < 8; i++) begin
                row_buf[i] <= '0;
                for (int j = 0; j < 8; j++) begin
                    y_buf[i][j] <= '0;
                    z_reg[i][j] <= '0;
                end
            end
        end else begin
            row_ready <= 1'b0;
            if (accept) begin
                // p - 128 is p with its MSB inverted, sign-extended to 9 bits.
                row_buf[count[2:0]] <= {{2{~data_in[PIX_W-1]}}, data_in[PIX_W-2:0]};
                count               <= count + 6'd1;
                output_enable       <= 1'b0;
                if (count[2:0] == 3'd7) begin
                    row_ready <= 1'b1;
                    row_idx   <= count[5:3];
                end
                if (count == 6'd63)
                    tmr <= 4'd9;
            end
            // The next row's first pixel may land in row_buf on this same edge;
            // the row pass still sees the completed row.
            if (row_ready) begin
                for (int u = 0; u < 8; u++)
                    y_buf[row_idx][u] <= row_dot[u];
            end
            if (state == COMPUTE) begin
                tmr <= tmr - 4'd1;
                if (col_active) begin
                    for (int v = 0; v < 8; v++)
                        z_reg[v][col_sel] <= round_sat(col_dot[v]);
                end
                if (tmr == 4'd1)
                    output_enable <= 1'b1;
            end
        end
    end

    assign Z11_final = z_reg[0][0]; assign Z12_final = z_reg[0][1]; assign Z13_final = z_reg[0][2]; assign Z14_final = z_reg[0][3];
    assign Z15_final = z_reg[0][4]; assign Z16_final = z_reg[0][5]; assign Z17_final = z_reg[0][6]; assign Z18_final = z_reg[0][7];
    assign Z21_final = z_reg[1][0]; assign Z22_final = z_reg[1][1]; assign Z23_final = z_reg[1][2]; assign Z24_final = z_reg[1][3];
    assign Z25_final = z_reg[1][4]; assign Z26_final = z_reg[1][5]; assign Z27_final = z_reg[1][6]; assign Z28_final = z_reg[1][7];
    assign Z31_final = z_reg[2][0]; assign Z32_final = z_reg[2][1]; assign Z33_final = z_reg[2][2]; assign Z34_final = z_reg[2][3];
    assign Z35_final = z_reg[2][4]; assign Z36_final = z_reg[2][5]; assign Z37_final = z_reg[2][6]; assign Z38_final = z_reg[2][7];
    assign Z41_final = z_reg[3][0]; assign Z42_final = z_reg[3][1]; assign Z43_final = z_reg[3][2]; assign Z44_final = z_reg[3][3];
    assign Z45_final = z_reg[3][4]; assign Z46_final = z_reg[3][5]; assign Z47_final = z_reg[3][6]; assign Z48_final = z_reg[3][7];
    assign Z51_final = z_reg[4][0]; assign Z52_final = z_reg[4][1]; assign Z53_final = z_reg[4][2]; assign Z54_final = z_reg[4][3];
    assign Z55_final = z_reg[4][4]; assign Z56_final = z_reg[4][5]; assign Z57_final = z_reg[4][6]; assign Z58_final = z_reg[4][7];
    assign Z61_final = z_reg[5][0]; assign Z62_final = z_reg[5][1]; assign Z63_final = z_reg[5][2]; assign Z64_final = z_reg[5][3];
    assign Z65_final = z_reg[5][4]; assign Z66_final = z_reg[5][5]; assign Z67_final = z_reg[5][6]; assign Z68_final = z_reg[5][7];
    assign Z71_final = z_reg[6][0]; assign Z72_final = z_reg[6][1]; assign Z73_final = z_reg[6][2]; assign Z74_final = z_reg[6][3];
    assign Z75_final = z_reg[6][4]; assign Z76_final = z_reg[6][5]; assign Z77_final = z_reg[6][6]; assign Z78_final = z_reg[6][7];
    assign Z81_final = z_reg[7][0]; assign Z82_final = z_reg[7][1]; assign Z83_final = z_reg[7][2]; assign Z84_final = z_reg[7][3];
    assign Z85_final = z_reg[7][4]; assign Z86_final = z_reg[7][5]; assign Z87_final = z_reg[7][6]; assign Z88_final = z_reg[7][7];

endmodule

// File: tb/tb_cb_dct.sv
// Self-checking bench for cb_dct: a block-level reference model (integer
// fixed-point DCT plus a double-precision DCT) with literal spot checks.
`timescale 1ns/1ps
module tb_cb_dct;

    logic       clk     = 1'b0;
    logic       rst     = 1'b1;
    logic       enable  = 1'b0;
    logic [7:0] data_in = 8'd0;
    logic       output_enable;
    wire signed [10:0] zw [8][8];

    cb_dct dut (
        .clk(clk), .rst(rst), .enable(enable), .data_in(data_in), .output_enable(output_enable),
        .Z11_final(zw[0][0]), .Z12_final(zw[0][1]), .Z13_final(zw[0][2]), .Z14_final(zw[0][3]), .Z15_final(zw[0][4]), .Z16_final(zw[0][5]), .Z17_final(zw[0][6]), .Z18_final(zw[0][7]),
        .Z21_final(zw[1][0]), .Z22_final(zw[1][1]), .Z23_final(zw[1][2]), .Z24_final(zw[1][3]), .Z25_final(zw[1][4]), .Z26_final(zw[1][5]), .Z27_final(zw[1][6]), .Z28_final(zw[1][7]),
        .Z31_final(zw[2][0]), .Z32_final(zw[2][1]), .Z33_final(zw[2][2]), .Z34_final(zw[2][3]), .Z35_final(zw[2][4]), .Z36_final(zw[2][5]), .Z37_final(zw[2][6]), .Z38_final(zw[2][7]),
        .Z41_final(zw[3][0]), .Z42_final(zw[3][1]), .Z43_final(zw[3][2]), .Z44_final(zw[3][3]), .Z45_final(zw[3][4]), .Z46_final(zw[3][5]), .Z47_final(zw[3][6]), .Z48_final(zw[3][7]),
        .Z51_final(zw[4][0]), .Z52_final(zw[4][1]), .Z53_final(zw[4][2]), .Z54_final(zw[4][3]), .Z55_final(zw[4][4]), .Z56_final(zw[4][5]), .Z57_final(zw[4][6]), .Z58_final(zw[4][7]),
        .Z61_final(zw[5][0]), .Z62_final(zw[5][1]), .Z63_final(zw[5][2]), .Z64_final(zw[5][3]), .Z65_final(zw[5][4]), .Z66_final(zw[5][5]), .Z67_final(zw[5][6]), .Z68_final(zw[5][7]),
        .Z71_final(zw[6][0]), .Z72_final(zw[6][1]), .Z73_final(zw[6][2]), .Z74_final(zw[6][3]), .Z75_final(zw[6][4]), .Z76_final(zw[6][5]), .Z77_final(zw[6][6]), .Z78_final(zw[6][7]),
        .Z81_final(zw[7][0]), .Z82_final(zw[7][1]), .Z83_final(zw[7][2]), .Z84_final(zw[7][3]), .Z85_final(zw[7][4]), .Z86_final(zw[7][5]), .Z87_final(zw[7][6]), .Z88_final(zw[7][7])
    );

    always #5 clk = ~clk;

    localparam real PI = 3.14159265358979323846;

    int n_checks = 0;
    int n_errors = 0;

    int coef   [8][8];
    int drv_pix[64];
    int m_pix  [64];
    int m_next [8][8];
    int m_z    [8][8];
    int m_n    = 0;
    int m_mode = 0;   // 0 accepting pixels, 1 transforming, 2 result held
    int m_wait = 0;
    bit m_oe   = 1'b0;

    function automatic real alpha(input int k);
        return (k == 0) ? $sqrt(0.125) : 0.5;
    endfunction

    function automatic void init_coef();
        real r;
        for (int u = 0; u < 8; u++)
            for (int x = 0; x < 8; x++) begin
                r = 4096.0 * alpha(u) * $cos(real'((2*x+1)*u) * PI / 16.0);
                coef[u][x] = (r >= 0.0) ? $rtoi(r + 0.5) : -$rtoi(0.5 - r);
            end
    endfunction

    // Fixed-point separable DCT of m_pix: full-precision sums, round half up, clamp.
    function automatic void model_block();
        longint y [8][8];
        longint w;
        longint q;
        for (int r = 0; r < 8; r++)
            for (int u = 0; u < 8; u++) begin
                y[r][u] = 0;
                for (int x = 0; x < 8; x++)
                    y[r][u] += longint'(m_pix[r*8+x] - 128) * longint'(coef[u][x]);
            end
        for (int v = 0; v < 8; v++)
            for (int u = 0; u < 8; u++) begin
                w = 0;
                for (int r = 0; r < 8; r++)
                    w += y[r][u] * longint'(coef[v][r]);
                q = (w + 64'sd8388608) >>> 24;
                if (q > 1023) q = 1023;
                if (q < -1024) q = -1024;
                m_next[v][u] = int'(q);
            end
    endfunction

    // Block-level behaviour: 64 accepted pixels, result visible 9 edges later,
    // held until the first pixel of the next block.
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_n = 0; m_mode = 0; m_wait = 0; m_oe = 1'b0;
            for (int v = 0; v < 8; v++)
                for (int u = 0; u < 8; u++)
                    m_z[v][u] = 0;
        end else begin
            case (m_mode)
                0: if (enable) begin
                    m_pix[m_n] = int'(data_in);
                    m_n++;
                    if (m_n == 64) begin
                        model_block();
                        m_mode = 1;
                        m_wait = 9;
                    end
                end
                1: begin
                    m_wait--;
                    if (m_wait == 0) begin
                        for (int v = 0; v < 8; v++)
                            for (int u = 0; u < 8; u++)
                                m_z[v][u] = m_next[v][u];
                        m_oe   = 1'b1;
                        m_mode = 2;
                    end
                end
                default: if (enable) begin
                    m_oe     = 1'b0;
                    m_pix[0] = int'(data_in);
                    m_n      = 1;
                    m_mode   = 0;
                end
            endcase
        end
    end

    always @(negedge clk) begin
        if (!rst) begin
            n_checks++;
            if (output_enable !== m_oe) begin
                n_errors++;
                $display("FAIL output_enable @%0t: got %b expected %b", $time, output_enable, m_oe);
            end
            if (m_oe) begin
                for (int v = 0; v < 8; v++)
                    for (int u = 0; u < 8; u++) begin
                        n_checks++;
                        if (int'(zw[v][u]) != m_z[v][u]) begin
                            n_errors++;
                            $display("FAIL model Z%0d%0d @%0t: got %0d expected %0d", v+1, u+1, $time, int'(zw[v][u]), m_z[v][u]);
                        end
                    end
            end
        end
    end

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic send_block(input int gap_pct, input int nsamp);
        for (int k = 0; k < nsamp; k++) begin
            while (gap_pct > 0 && int'($urandom_range(99, 0)) < gap_pct) begin
                enable = 1'b0;
                @(negedge clk);
            end
            enable  = 1'b1;
            data_in = 8'(drv_pix[k]);
            @(negedge clk);
        end
        enable = 1'b0;
    endtask

    task automatic wait_done(output int lat);
        lat = 0;
        while (output_enable !== 1'b1 && lat < 30) begin
            @(negedge clk);
            lat++;
        end
        n_checks++;
        if (output_enable !== 1'b1) begin
            n_errors++;
            $display("FAIL done_timeout: output_enable still %b after %0d cycles", output_enable, lat);
        end
    endtask

    task automatic fill_const(input int p);
        for (int k = 0; k < 64; k++) drv_pix[k] = p;
    endtask

    task automatic const_check(input string name, input int dc);
        for (int v = 0; v < 8; v++)
            for (int u = 0; u < 8; u++)
                chk($sformatf("%s_Z%0d%0d", name, v+1, u+1), int'(zw[v][u]), (v == 0 && u == 0) ? dc : 0);
    endtask

    task automatic ref_check(input string name);
        real acc;
        real d;
        for (int v = 0; v < 8; v++)
            for (int u = 0; u < 8; u++) begin
                acc = 0.0;
                for (int r = 0; r < 8; r++)
                    for (int x = 0; x < 8; x++)
                        acc += real'(drv_pix[r*8+x] - 128) * $cos(real'((2*x+1)*u) * PI / 16.0)
                               * $cos(real'((2*r+1)*v) * PI / 16.0);
                acc = acc * alpha(u) * alpha(v);
                d = real'(int'(zw[v][u])) - acc;
                n_checks++;
                if (d > 1.0 || d < -1.0) begin
                    n_errors++;
                    $display("FAIL %s_Z%0d%0d: got %0d reference %f", name, v+1, u+1, int'(zw[v][u]), acc);
                end
            end
    endtask

    task automatic hold(input int n);
        enable = 1'b0;
        repeat (n) @(negedge clk);
    endtask

    initial begin
        int lat;
        int z88;
        init_coef();
        chk("coef_dc", coef[0][3], 1448);
        chk("coef_c1", coef[1][0], 2009);
        chk("coef_u7x7", coef[7][7], -400);

        rst = 1'b1;
        repeat (3) @(negedge clk);
        chk("rst_oe", int'(output_enable), 0);
        const_check("rst", 0);
        rst = 1'b0;
        @(negedge clk);

        fill_const(8'h80);
        send_block(0, 64);
        wait_done(lat);
        chk("latency", lat, 9);
        const_check("c80", 0);
        hold(3);

        fill_const(8'h40);
        send_block(0, 64);
        wait_done(lat);
        const_check("c40", -512);
        hold(2);

        fill_const(8'h00);
        send_block(10, 64);
        wait_done(lat);
        const_check("c00", -1024);
        hold(2);

        fill_const(8'hFF);
        send_block(10, 64);
        wait_done(lat);
        const_check("cFF", 1016);
        hold(2);

        for (int k = 0; k < 64; k++)
            drv_pix[k] = (((k & 1) ^ ((k >> 3) & 1)) != 0) ? 0 : 255;
        send_block(0, 64);
        wait_done(lat);
        chk("chk_Z11", int'(zw[0][0]), -4);
        z88 = int'(zw[7][7]);
        n_checks++;
        if (z88 < 836 || z88 > 839) begin
            n_errors++;
            $display("FAIL chk_Z88: got %0d expected 836..839", z88);
        end
        hold(2);

        for (int b = 0; b < 6; b++) begin
            for (int k = 0; k < 64; k++) drv_pix[k] = int'($urandom_range(255, 0));
            send_block(25, 64);
            wait_done(lat);
            ref_check($sformatf("rand%0d", b));
            hold(int'($urandom_range(3, 1)));
        end

        for (int k = 0; k < 64; k++) drv_pix[k] = int'($urandom_range(255, 0));
        send_block(0, 30);
        #2 rst = 1'b1;
        #1;
        chk("midrst_oe", int'(output_enable), 0);
        const_check("midrst", 0);
        @(negedge clk);
        #2 rst = 1'b0;
        @(negedge clk);

        fill_const(8'h40);
        send_block(0, 64);
        for (int k = 0; k < 5; k++) begin
            enable  = 1'b1;
            data_in = 8'($urandom_range(255, 0));
            @(negedge clk);
        end
        enable = 1'b0;
        wait_done(lat);
        chk("after_rst_Z11", int'(zw[0][0]), -512);
        hold(4);
        chk("held_oe", int'(output_enable), 1);
        enable  = 1'b1;
        data_in = 8'h40;
        @(negedge clk);
        enable = 1'b0;
        chk("newblk_oe", int'(output_enable), 0);
        chk("newblk_Z11_kept", int'(zw[0][0]), -512);
        hold(2);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
